// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared defaults, mode encodings and clog2 helper for the scan config block
package scan_pkg;

  localparam int CHAIN_LEN_DEF    = 64;
  localparam int STAT_LEN_DEF     = 32;
  localparam int SYNC_STAGES_DEF  = 2;
  localparam int DIV_LOG2_MAX_DEF = 10;

  localparam logic MODE_WR = 1'b0;
  localparam logic MODE_RD = 1'b1;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop pad synchronizer with rising-edge pulse
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sr;
  logic              q_d;
  logic [STAGES:0]   armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      q_d   <= 1'b0;
      armed <= '0;
    end else begin
      sr    <= {sr[STAGES-2:0], d};
      q_d   <= sr[STAGES-1];
      armed <= {armed[STAGES-1:0], 1'b1};
    end
  end

  // Edges are suppressed until q_d holds a real post-reset sample, so a pad
  // already high at reset release never produces a pulse.
  assign q    = sr[STAGES-1];
  assign rise = q & ~q_d & armed[STAGES];

endmodule

// File: rtl/scan_cfg_ctrl.sv
// rtl/scan_cfg_ctrl.sv - scan shift chain with shadow config register, status readback and clock monitor
module scan_cfg_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN    = CHAIN_LEN_DEF,
  parameter int STAT_LEN     = STAT_LEN_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DIV_LOG2_MAX = DIV_LOG2_MAX_DEF,
  parameter logic [CHAIN_LEN-1:0] CFG_RESET = '0
) (
  input  logic                                 clk_signal_ext,
  input  logic                                 rst_n,
  input  logic                                 phi,
  input  logic                                 phib,
  input  logic                                 scan_i0o1,
  input  logic                                 load,
  input  logic                                 scan_in,
  input  logic [STAT_LEN-1:0]                  status_in,
  input  logic [clog2(DIV_LOG2_MAX+1)-1:0]     div_sel,
  output logic                                 scan_out,
  output logic [CHAIN_LEN-1:0]                 cfg_out,
  output logic                                 cfg_valid,
  output logic                                 phi_out,
  output logic                                 phib_out,
  output logic                                 scan_i0o1_out,
  output logic                                 load_out,
  output logic                                 clk_div_out,
  output logic                                 overlap_err
);

  localparam int DW = clog2(DIV_LOG2_MAX+1);
  localparam logic [DW-1:0] DMAX = DW'(DIV_LOG2_MAX);

  logic phi_s, phib_s, mode_s, load_s, scan_in_s;
  logic phi_rise, phib_rise, load_rise, mode_rise_unused, scan_in_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_phi (
    .clk(clk_signal_ext), .rst_n(rst_n), .d(phi), .q(phi_s), .rise(phi_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_phib (
    .clk(clk_signal_ext), .rst_n(rst_n), .d(phib), .q(phib_s), .rise(phib_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk(clk_signal_ext), .rst_n(rst_n), .d(scan_i0o1), .q(mode_s), .rise(mode_rise_unused));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk_signal_ext), .rst_n(rst_n), .d(load), .q(load_s), .rise(load_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sin (
    .clk(clk_signal_ext), .rst_n(rst_n), .d(scan_in), .q(scan_in_s), .rise(scan_in_rise_unused));

  logic [CHAIN_LEN-1:0]    chain;
  logic                    m;
  logic [DIV_LOG2_MAX-1:0] cnt;
  logic [DW-1:0]           sel_c;
  logic                    div_bit;

  always_comb begin
    sel_c   = (div_sel > DMAX) ? DMAX : div_sel;
    div_bit = 1'b0;
    for (int i = 1; i <= DIV_LOG2_MAX; i++) begin
      if (sel_c == DW'(i)) div_bit = cnt[i-1];
    end
  end

  always_ff @(posedge clk_signal_ext or negedge rst_n) begin
    if (!rst_n) begin
      chain         <= '0;
      m             <= 1'b0;
      cfg_out       <= CFG_RESET;
      cfg_valid     <= 1'b0;
      overlap_err   <= 1'b0;
      phi_out       <= 1'b0;
      phib_out      <= 1'b0;
      scan_i0o1_out <= 1'b0;
      load_out      <= 1'b0;
      cnt           <= '0;
      clk_div_out   <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      if (phi_rise) m <= scan_in_s;
      // Load wins over a coincident shift; the lost shift is flagged below.
      if (load_rise) begin
        if (mode_s == MODE_WR) begin
          cfg_out   <= chain;
          cfg_valid <= 1'b1;
        end else begin
          chain[STAT_LEN-1:0] <= status_in;
        end
      end else if (phib_rise) begin
        chain <= {chain[CHAIN_LEN-2:0], m};
      end
      if ((load_rise && phib_rise) || (phi_s && phib_s)) overlap_err <= 1'b1;
      phi_out       <= phi_s;
      phib_out      <= phib_s;
      scan_i0o1_out <= mode_s;
      load_out      <= load_s;
      cnt           <= cnt + 1'b1;
      clk_div_out   <= div_bit;
    end
  end

  assign scan_out = chain[CHAIN_LEN-1];

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// tb/tb_scan_cfg_ctrl.sv - randomized self-checking bench for scan_cfg_ctrl against a transaction-level model
module tb_scan_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phi = 1'b0, phib = 1'b0, scan_i0o1 = 1'b0, load = 1'b0, scan_in = 1'b0;
  logic [31:0] status_in = '0;
  logic [3:0]  div_sel = '0;
  logic        scan_out, cfg_valid, phi_out, phib_out, scan_i0o1_out, load_out;
  logic        clk_div_out, overlap_err;
  logic [63:0] cfg_out;

  int          n_checks = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  logic [63:0] chain_m = '0;
  logic [63:0] cfg_m = '0;

  scan_cfg_ctrl dut (
    .clk_signal_ext(clk), .rst_n(rst_n), .phi(phi), .phib(phib),
    .scan_i0o1(scan_i0o1), .load(load), .scan_in(scan_in),
    .status_in(status_in), .div_sel(div_sel), .scan_out(scan_out),
    .cfg_out(cfg_out), .cfg_valid(cfg_valid), .phi_out(phi_out),
    .phib_out(phib_out), .scan_i0o1_out(scan_i0o1_out), .load_out(load_out),
    .clk_div_out(clk_div_out), .overlap_err(overlap_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_valid) valid_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    scan_in = b;
    phi = 1'b1;  cyc(4);
    phi = 1'b0;  cyc(4);
    phib = 1'b1; cyc(4);
    phib = 1'b0; cyc(4);
    chain_m = {chain_m[62:0], b};
  endtask

  task automatic do_load(input logic md, input logic [31:0] st, output int lat);
    scan_i0o1 = md;
    status_in = st;
    cyc(4);
    valid_cnt = 0;
    load = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (lat < 0 && cfg_valid) lat = k;
    end
    load = 1'b0;
    cyc(4);
    if (md == 1'b0) cfg_m = chain_m;
    else chain_m[31:0] = st;
    check("load_cfg_out", cfg_out, cfg_m);
    check("load_valid_pulses", 64'(valid_cnt), (md == 1'b0) ? 64'd1 : 64'd0);
    check("load_scan_out", 64'(scan_out), 64'(chain_m[63]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(6);
    chain_m = '0;
    cfg_m   = '0;
  endtask

  task automatic measure_period(output int per);
    int first;
    logic prev, cur;
    first = -1;
    per   = -1;
    prev  = clk_div_out;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      cur = clk_div_out;
      if (cur && !prev) begin
        if (first < 0) first = k;
        else begin
          per = k - first;
          break;
        end
      end
      prev = cur;
    end
  endtask

  initial begin
    int lat, per, ones, n, s;
    logic [63:0] pat, got;

    cyc(3);
    check("rst_cfg_out", cfg_out, 64'h0);
    check("rst_scan_out", 64'(scan_out), 64'h0);
    check("rst_cfg_valid", 64'(cfg_valid), 64'h0);
    check("rst_overlap", 64'(overlap_err), 64'h0);
    check("rst_echoes", 64'({phi_out, phib_out, scan_i0o1_out, load_out}), 64'h0);
    check("rst_clk_div", 64'(clk_div_out), 64'h0);
    rst_n = 1'b1;
    cyc(6);

    pat = 64'hA5A5_0000_FFFF_1234;
    for (int i = 63; i >= 0; i--) shift_bit(pat[i]);
    do_load(1'b0, 32'h0, lat);
    check("wr_cfg_pattern", cfg_out, 64'hA5A5_0000_FFFF_1234);
    check("load_latency", 64'(lat), 64'd3);

    do_load(1'b1, 32'hDEAD_BEEF, lat);
    check("rd_cfg_unchanged", cfg_out, 64'hA5A5_0000_FFFF_1234);
    got = '0;
    for (int i = 0; i < 64; i++) begin
      got = {got[62:0], scan_out};
      shift_bit(1'($urandom_range(0, 1)));
    end
    check("readback_stream", got, 64'hA5A5_0000_DEAD_BEEF);
    check("readback_overlap_clear", 64'(overlap_err), 64'h0);

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 70);
      for (int i = 0; i < n; i++) shift_bit(1'($urandom_range(0, 1)));
      do_load(1'($urandom_range(0, 1)), $urandom, lat);
    end
    check("random_overlap_clear", 64'(overlap_err), 64'h0);

    shift_bit(1'b0);
    scan_in = 1'b1;
    phi = 1'b1; cyc(4);
    phi = 1'b0; cyc(4);
    scan_i0o1 = 1'b0; cyc(4);
    valid_cnt = 0;
    phib = 1'b1; load = 1'b1; cyc(6);
    phib = 1'b0; load = 1'b0; cyc(4);
    cfg_m = chain_m;
    check("collide_cfg_out", cfg_out, cfg_m);
    check("collide_valid", 64'(valid_cnt), 64'd1);
    check("collide_overlap", 64'(overlap_err), 64'h1);
    do_load(1'b0, 32'h0, lat);

    do_reset();
    check("reset_overlap_clear", 64'(overlap_err), 64'h0);
    phi = 1'b1; phib = 1'b1;
    cyc(2);
    check("echo_phi_early", 64'(phi_out), 64'h0);
    cyc(1);
    check("echo_phi", 64'(phi_out), 64'h1);
    check("echo_phib", 64'(phib_out), 64'h1);
    phi = 1'b0; phib = 1'b0;
    cyc(6);
    check("both_high_overlap", 64'(overlap_err), 64'h1);
    cyc(50);
    check("overlap_sticky", 64'(overlap_err), 64'h1);
    scan_i0o1 = 1'b1; cyc(4);
    check("echo_mode", 64'(scan_i0o1_out), 64'h1);
    scan_i0o1 = 1'b0;
    do_reset();
    check("overlap_cleared", 64'(overlap_err), 64'h0);

    for (int i = 0; i < 20; i++) shift_bit(1'($urandom_range(0, 1)));
    do_reset();
    do_load(1'b0, 32'h0, lat);
    check("midshift_reset_cfg", cfg_out, 64'h0);

    div_sel = 4'd10; cyc(2);
    measure_period(per);
    check("div10_period", 64'(per), 64'd1024);
    div_sel = 4'd0; cyc(2);
    ones = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (clk_div_out) ones++;
    end
    check("div0_constant", 64'(ones), 64'd0);
    div_sel = 4'd15; cyc(2);
    measure_period(per);
    check("div15_clamped", 64'(per), 64'd1024);
    for (int it = 0; it < 3; it++) begin
      s = $urandom_range(1, 9);
      div_sel = 4'(s); cyc(2);
      measure_period(per);
      check("div_random_period", 64'(per), 64'(1 << s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_cfg_ctrl.md
SCAN_CFG_CTRL -- requirements
Module: scan_cfg_ctrl

Parameters (name, default, meaning)
- CHAIN_LEN, 64: scan shift-chain length in bits.
- STAT_LEN, 32: status capture width; must satisfy 1 <= STAT_LEN <= CHAIN_LEN.
- SYNC_STAGES, 2: synchronizer depth on every scan pad input; minimum 2.
- DIV_LOG2_MAX, 10: maximum divider exponent; default gives divide-by-1024.
- CFG_RESET, 0: reset value of cfg_out, CHAIN_LEN bits.

Interface (name, direction, width, meaning)
REQ-001 clk_signal_ext  in  1  sole clock; all logic on its rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 phi  in  1  external scan master phase, asynchronous to clk_signal_ext.
REQ-004 phib  in  1  external scan slave phase, asynchronous.
REQ-005 scan_i0o1  in  1  mode select: 0 = configure/write, 1 = readback.
REQ-006 load  in  1  external load strobe, asynchronous.
REQ-007 scan_in  in  1  serial data in.
REQ-008 status_in  in  STAT_LEN  internal status word to capture in readback mode.
REQ-009 div_sel  in  clog2(DIV_LOG2_MAX+1)  divider exponent select.
REQ-010 scan_out  out  1  serial data out; equals chain MSB (chain[CHAIN_LEN-1]).
REQ-011 cfg_out  out  CHAIN_LEN  shadow configuration register.
REQ-012 cfg_valid  out  1  one-cycle pulse on each cfg_out update.
REQ-013 phi_out, phib_out, scan_i0o1_out, load_out  out  1 each  registered echoes of the synchronized inputs.
REQ-014 clk_div_out  out  1  registered divided-clock monitor output.
REQ-015 overlap_err  out  1  sticky flag for phase-overlap or collision errors.

Function
REQ-016 Each of phi, phib, scan_i0o1, load and scan_in shall pass through SYNC_STAGES flops; phi, phib and load shall each produce a one-cycle rising-edge pulse.
REQ-017 On a phi rise, the synchronized scan_in shall be captured into a master bit m.
REQ-018 On a phib rise with no load rise in the same cycle, the chain shall shift: chain <= {chain[CHAIN_LEN-2:0], m}.
REQ-019 Latency from a pad edge to the resulting state change shall be exactly SYNC_STAGES+1 clk_signal_ext cycles.
REQ-020 On a load rise with scan_i0o1=0: cfg_out <= chain, and cfg_valid shall be 1 in the following cycle only.
REQ-021 On a load rise with scan_i0o1=1: chain[STAT_LEN-1:0] <= status_in, upper chain bits unchanged, cfg_out unchanged, no cfg_valid.
REQ-022 A load rise and a phib rise in the same cycle: the load action executes, the shift is dropped, and overlap_err is set.
REQ-023 overlap_err shall also be set in any cycle where synchronized phi and phib are both 1; it clears only on reset.
REQ-024 Echo outputs shall equal the synchronized inputs delayed one further register.
REQ-025 A DIV_LOG2_MAX-bit free-running counter shall increment every cycle and wrap from all-ones to 0.
REQ-026 clk_div_out selection, registered:
- div_sel=0: clk_div_out held 0.
- 1 <= div_sel <= DIV_LOG2_MAX: clk_div_out <= cnt[div_sel-1], i.e. divide by 2^div_sel.
- div_sel > DIV_LOG2_MAX: clamped to DIV_LOG2_MAX.
REQ-027 A div_sel change shall take effect the next cycle without resetting the counter; glitches are acceptable (monitor output only).

Reset
REQ-028 While rst_n=0, all outputs shall be reset: cfg_out=CFG_RESET; scan_out, cfg_valid, echoes, clk_div_out, overlap_err = 0.
REQ-029 While rst_n=0, chain, m, synchronizers, edge history and counter shall be 0.
REQ-030 Reset asserted mid-shift shall discard the partial chain.
REQ-031 No edge pulse shall be generated from an input already high when reset is released.

Structure
REQ-032 The shared package scan_pkg shall hold the parameter defaults, the mode encoding constants (MODE_WR=0, MODE_RD=1) and the clog2 function.
REQ-033 Sub-module sync_edge (SYNC_STAGES synchronizer + rising-edge detect, asynchronous reset) shall be instantiated per input.

Verification
REQ-034 Shift 64 bits 0xA5A5_0000_FFFF_1234 MSB-first with scan_i0o1=0, then load -> cfg_out=0xA5A5_0000_FFFF_1234 and one cfg_valid pulse.
REQ-035 scan_i0o1=1, status_in=0xDEADBEEF, load, then 64 phi/phib pairs -> scan_out presents 0xDEADBEEF in the low 32 bits, upper 32 bits hold the previous chain contents.
REQ-036 phi and phib driven high together for 3 cycles -> overlap_err=1 and stays 1 until rst_n=0.
REQ-037 div_sel=10 -> clk_div_out period 1024 cycles; div_sel=0 -> constant 0; div_sel=15 -> period 1024 (clamped).
REQ-038 rst_n pulsed low after 20 shifts, then load with scan_i0o1=0 -> cfg_out=0 (CFG_RESET).
REQ-039 phib rise and load rise in the same cycle -> no shift, load performed, overlap_err=1.
